// File: rtl/div_share_arbiter_if.sv
// Requester-side bus of div_share_arbiter: per-FU operand request channel plus
// shared result response channel. master = FU array, slave = arbiter.
interface div_share_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned N_BITS = 32
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*N_BITS-1:0] req_a_i;
  logic [N_REQ*N_BITS-1:0] req_b_i;
  logic [N_REQ-1:0]        req_signed_i;
  logic [N_REQ-1:0]        resp_valid_o;
  logic [N_REQ-1:0]        resp_ready_i;
  logic [N_BITS-1:0]       resp_q_o;
  logic [N_BITS-1:0]       resp_r_o;

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_signed_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_q_o, resp_r_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_signed_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_q_o, resp_r_o
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one iterative divider among N_REQ functional units.
// Optional macro DIV_SHARE_ZERO_BYPASS_EN answers divide-by-zero locally without the divider.
module div_share_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned N_BITS = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  div_share_arbiter_if.slave       req_if,
  output logic                     div_in_valid_o,
  output logic [N_BITS-1:0]        div_a_o,
  output logic [N_BITS-1:0]        div_b_o,
  output logic                     div_signed_o,
  input  logic                     div_valid_i,
  input  logic [N_BITS-1:0]        div_q_i,
  input  logic [N_BITS-1:0]        div_r_i,
  output logic                     busy_o,
  output logic [$clog2(N_REQ)-1:0] owner_o
);
  localparam int unsigned   OW   = $clog2(N_REQ);
  localparam logic [OW-1:0] LAST = OW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [OW-1:0]     rr_ptr;
  logic              grant_vld;
  logic [OW-1:0]     grant_idx;
  logic [N_REQ-1:0]  grant_oh;
  logic [N_BITS-1:0] grant_a;
  logic [N_BITS-1:0] grant_b;
  logic              grant_signed;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin : grant_scan
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_vld && req_if.req_valid_i[OW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = OW'(idx);
      end
    end
    grant_oh     = grant_vld ? (N_REQ'(1) << grant_idx) : '0;
    grant_a      = req_if.req_a_i[32'(grant_idx) * N_BITS +: N_BITS];
    grant_b      = req_if.req_b_i[32'(grant_idx) * N_BITS +: N_BITS];
    grant_signed = req_if.req_signed_i[grant_idx];
  end

  // Accept is combinational so a grant costs no extra cycle
  assign req_if.req_ready_o = (state == IDLE) ? grant_oh : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      owner_o             <= '0;
      busy_o              <= 1'b0;
      div_in_valid_o      <= 1'b0;
      div_a_o             <= '0;
      div_b_o             <= '0;
      div_signed_o        <= 1'b0;
      req_if.resp_valid_o <= '0;
      req_if.resp_q_o     <= '0;
      req_if.resp_r_o     <= '0;
    end else begin
      div_in_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            owner_o      <= grant_idx;
            busy_o       <= 1'b1;
            div_a_o      <= grant_a;
            div_b_o      <= grant_b;
            div_signed_o <= grant_signed;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
            // Divide-by-zero result is fixed, so skip the divider entirely
            if (grant_b == '0) begin
              state               <= RESP;
              req_if.resp_valid_o <= grant_oh;
              req_if.resp_q_o     <= '1;
              req_if.resp_r_o     <= grant_a;
            end else begin
              state          <= ISSUE;
              div_in_valid_o <= 1'b1;
            end
`else
            state          <= ISSUE;
            div_in_valid_o <= 1'b1;
`endif
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (div_valid_i) begin
            state               <= RESP;
            req_if.resp_valid_o <= N_REQ'(1) << owner_o;
            req_if.resp_q_o     <= div_q_i;
            req_if.resp_r_o     <= div_r_i;
          end
        end
        RESP: begin
          if (req_if.resp_ready_i[owner_o]) begin
            state               <= IDLE;
            rr_ptr              <= (owner_o == LAST) ? '0 : owner_o + OW'(1);
            owner_o             <= '0;
            busy_o              <= 1'b0;
            req_if.resp_valid_o <= '0;
            req_if.resp_q_o     <= '0;
            req_if.resp_r_o     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
